// File: rtl/adc_pkg.sv
// Shared types and default sizes for the ADC capture engine.
package adc_pkg;

    localparam int DATA_W_DEFAULT     = 8;
    localparam int DEPTH_LOG2_DEFAULT = 10;
    localparam int WORD_W_DEFAULT     = 2 * DATA_W_DEFAULT;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        FILL,
        READOUT
    } state_t;

    function automatic int word_width(input int data_w);
        return 2 * data_w;
    endfunction

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port record buffer: one write port, one registered read port.
module capture_ram
    import adc_pkg::*;
#(
    parameter int ADDR_W = DEPTH_LOG2_DEFAULT,
    parameter int WORD_W = WORD_W_DEFAULT
) (
    input  logic              CLK_200M,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data
);

    // No reset on the array or the read register so the tools map this onto block RAM.
    logic [WORD_W-1:0] mem [0:(1 << ADDR_W) - 1];

    always_ff @(posedge CLK_200M) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge CLK_200M) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/adc_capture.sv
// Two-channel ADC sample capture: strobe detect, level/edge trigger, record fill
// into capture_ram, and a bubble-free valid/ready readout.
module adc_capture
    import adc_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEFAULT,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
    input  logic                    CLK_200M,
    input  logic                    RST,
    input  logic                    ADC1_flag,
    input  logic [DATA_W-1:0]       ADC1_DATA,
    input  logic [DATA_W-1:0]       ADC2_DATA,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    trig_en,
    input  logic                    trig_edge,
    input  logic [DATA_W-1:0]       trig_level,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [2*DATA_W-1:0]     rd_data,
    output logic                    busy,
    output logic                    done,
    output logic [DEPTH_LOG2:0]     sample_cnt
);

    localparam int WORD_W = word_width(DATA_W);
    localparam int CNT_W  = DEPTH_LOG2 + 1;
    localparam logic [CNT_W-1:0] RECORD_LEN = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [CNT_W-1:0] LAST_CNT   = {1'b0, {DEPTH_LOG2{1'b1}}};

    state_t              state;
    logic [DATA_W-1:0]   ch1_q;
    logic [DATA_W-1:0]   ch2_q;
    logic                flag_q;
    logic                flag_d1;
    logic                strobe;
    logic [DATA_W-1:0]   prev1;
    logic                prev_valid;
    logic                trig_hit;

    logic                wr_en;
    logic [DEPTH_LOG2-1:0] wr_addr;
    logic [WORD_W-1:0]   wr_data;

    logic [CNT_W-1:0]    fetch_cnt;
    logic                inflight;
    logic [1:0]          occ;
    logic [2:0]          level;
    logic [WORD_W-1:0]   skid;
    logic [WORD_W-1:0]   ram_q;
    logic                pop;
    logic                fetch;
    logic                last_pop;

    always_ff @(posedge CLK_200M) begin
        if (RST) begin
            ch1_q   <= '0;
            ch2_q   <= '0;
            flag_q  <= 1'b0;
            flag_d1 <= 1'b0;
        end else begin
            ch1_q   <= ADC1_DATA;
            ch2_q   <= ADC2_DATA;
            flag_q  <= ADC1_flag;
            flag_d1 <= flag_q;
        end
    end

    // One strobe per flag pulse no matter how long the generator holds the flag.
    assign strobe  = flag_q & ~flag_d1;
    assign wr_data = {ch2_q, ch1_q};

    always_comb begin
        trig_hit = 1'b0;
        if (!trig_en) begin
            trig_hit = 1'b1;
        end else if (prev_valid) begin
            if (trig_edge) begin
                trig_hit = (prev1 > trig_level) && (ch1_q <= trig_level);
            end else begin
                trig_hit = (prev1 < trig_level) && (ch1_q >= trig_level);
            end
        end
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = sample_cnt[DEPTH_LOG2-1:0];
        if (!RST && !abort && strobe) begin
            if (state == ARMED && trig_hit) begin
                wr_en   = 1'b1;
                wr_addr = '0;
            end else if (state == FILL) begin
                wr_en = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK_200M) begin
        if (RST) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            sample_cnt <= '0;
            prev1      <= '0;
            prev_valid <= 1'b0;
        end else if (abort) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            sample_cnt <= '0;
            prev_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= ARMED;
                        busy       <= 1'b1;
                        sample_cnt <= '0;
                        prev_valid <= 1'b0;
                    end
                end
                ARMED: begin
                    if (strobe) begin
                        prev1      <= ch1_q;
                        prev_valid <= 1'b1;
                        if (trig_hit) begin
                            sample_cnt <= CNT_W'(1);
                            state      <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (strobe) begin
                        sample_cnt <= sample_cnt + CNT_W'(1);
                        if (sample_cnt == LAST_CNT) begin
                            state <= READOUT;
                            done  <= 1'b1;
                        end
                    end
                end
                READOUT: begin
                    if (last_pop) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        done       <= 1'b0;
                        sample_cnt <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Issue a read only when the word it returns next cycle is guaranteed a slot
    // in the two-entry output buffer, counting the read already in flight.
    assign pop      = rd_valid & rd_ready;
    assign level    = {1'b0, occ} + {2'b00, inflight};
    assign fetch    = (state == READOUT) && (fetch_cnt != RECORD_LEN)
                      && (level <= ({2'b00, pop} + 3'd1));
    assign last_pop = pop && (occ == 2'd1) && !inflight && (fetch_cnt == RECORD_LEN);

    capture_ram #(
        .ADDR_W (DEPTH_LOG2),
        .WORD_W (WORD_W)
    ) u_ram (
        .CLK_200M (CLK_200M),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_en    (fetch),
        .rd_addr  (fetch_cnt[DEPTH_LOG2-1:0]),
        .rd_data  (ram_q)
    );

    always_ff @(posedge CLK_200M) begin
        if (RST) begin
            fetch_cnt <= '0;
            inflight  <= 1'b0;
            occ       <= 2'd0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            skid      <= '0;
        end else if (abort || state != READOUT) begin
            fetch_cnt <= '0;
            inflight  <= 1'b0;
            occ       <= 2'd0;
            rd_valid  <= 1'b0;
        end else begin
            inflight <= fetch;
            if (fetch) begin
                fetch_cnt <= fetch_cnt + CNT_W'(1);
            end
            case (occ)
                2'd0: begin
                    if (inflight) begin
                        rd_data  <= ram_q;
                        occ      <= 2'd1;
                        rd_valid <= 1'b1;
                    end
                end
                2'd1: begin
                    if (pop && inflight) begin
                        rd_data <= ram_q;
                    end else if (pop) begin
                        occ      <= 2'd0;
                        rd_valid <= 1'b0;
                    end else if (inflight) begin
                        skid <= ram_q;
                        occ  <= 2'd2;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        rd_data <= skid;
                        if (inflight) begin
                            skid <= ram_q;
                        end else begin
                            occ <= 2'd1;
                        end
                    end
                end
                default: begin
                    occ      <= 2'd0;
                    rd_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
